// File: rtl/nexys_starship_spawn_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : nexys_starship_spawn_sched_pkg
//  Purpose  : Shared definitions for the Nexys Starship spawn scheduler:
//             direction indices, scheduler state encoding and small helpers
//             for moving between port bit order and direction-index order.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package nexys_starship_spawn_sched_pkg;

   // Direction indices. Round-robin order walks these 0 -> 3 and wraps.
   localparam int DIR_TOP   = 0;
   localparam int DIR_BTM   = 1;
   localparam int DIR_LEFT  = 2;
   localparam int DIR_RIGHT = 3;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRACE = 2'd1,
      S_RUN   = 2'd2
   } sched_state_t;

   // Port vectors are packed {top,btm,left,right}, i.e. top is bit 3, while
   // the arbiter works in direction-index order (top = index 0). This swap
   // is its own inverse, so it converts in both directions.
   function automatic logic [3:0] swap_order(input logic [3:0] v);
      logic [3:0] r;
      r            = '0;
      r[DIR_TOP]   = v[3];
      r[DIR_BTM]   = v[2];
      r[DIR_LEFT]  = v[1];
      r[DIR_RIGHT] = v[0];
      return r;
   endfunction

   // Index of the set bit in a one-hot vector (0 when empty).
   function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
      logic [1:0] r;
      r = 2'd0;
      for (int k = 0; k < 4; k++) begin
         if (oh[k]) r = 2'(k);
      end
      return r;
   endfunction

   function automatic logic [2:0] popcount4(input logic [3:0] v);
      return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
   endfunction

endpackage
`default_nettype wire

// File: rtl/nexys_starship_rr_arb4.sv
`default_nettype none
// ============================================================================
//  Module   : nexys_starship_rr_arb4
//  Purpose  : Combinational 4-way round-robin pick. Searches req starting at
//             index ptr, wrapping 3 -> 0, and grants the first set bit.
//  Ports    : req [3:0]  request vector (direction-index order)
//             ptr [1:0]  index that has highest priority this pick
//             gnt [3:0]  one-hot grant (zero when no request)
//             any        at least one request present
//  Revision : 1.0  initial release
// ============================================================================
module nexys_starship_rr_arb4 (
   input  logic [3:0] req,
   input  logic [1:0] ptr,
   output logic [3:0] gnt,
   output logic       any
);

   logic [1:0] idx;

   always_comb begin
      gnt = '0;
      idx = '0;
      for (int k = 0; k < 4; k++) begin
         idx = ptr + 2'(k);
         if (req[idx] && (gnt == 4'b0000)) begin
            gnt[idx] = 1'b1;
         end
      end
      any = |req;
   end

endmodule
`default_nettype wire

// File: rtl/nexys_starship_spawn_sched.sv
`default_nettype none
// ============================================================================
//  Module   : nexys_starship_spawn_sched
//  Purpose  : Monster-spawn scheduler. Latches per-direction PRNG spawn flags
//             as pending requests and grants at most one spawn per game tick
//             using round-robin arbitration, a post-grant cooldown and a cap
//             on simultaneously occupied directions.
//  Ports    : Clk               system clock
//             Reset             asynchronous active-high reset
//             tick              1-cycle game-rate strobe
//             game_active       game running; low aborts and clears
//             rand_req    [3:0] {top,btm,left,right} PRNG spawn flags
//             slot_clear  [3:0] per-direction monster gone, 1-cycle pulse
//             spawn       [3:0] one-hot 1-cycle spawn pulse
//             occupied    [3:0] direction currently holds a monster
//             active_count[2:0] popcount(occupied)
//             spawn_total [7:0] saturating grant counter
//  Config   : NEXYS_STARSHIP_SPAWN_RAMP_EN - when defined, the cooldown
//             reload shrinks by one every RAMP_SPAWNS grants down to
//             MIN_COOLDOWN, and returns to COOLDOWN_TICKS on game abort.
//  Revision : 1.0  initial release
// ============================================================================
module nexys_starship_spawn_sched
   import nexys_starship_spawn_sched_pkg::*;
#(
   parameter int MAX_ACTIVE     = 3,
   parameter int COOLDOWN_TICKS = 4,
   parameter int GRACE_TICKS    = 8
`ifdef NEXYS_STARSHIP_SPAWN_RAMP_EN
   ,
   parameter int MIN_COOLDOWN   = 1,
   parameter int RAMP_SPAWNS    = 8
`endif
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       tick,
   input  logic       game_active,
   input  logic [3:0] rand_req,
   input  logic [3:0] slot_clear,
   output logic [3:0] spawn,
   output logic [3:0] occupied,
   output logic [2:0] active_count,
   output logic [7:0] spawn_total
);

   sched_state_t state;
   sched_state_t state_nxt;

   logic [7:0] grace_cnt;
   logic [3:0] pend;
   logic [3:0] occ;
   logic [3:0] spawn_q;
   logic [3:0] cooldown;
   logic [1:0] rr_ptr;
   logic [7:0] total;
   logic [3:0] reload;

   logic [3:0] elig_dir;
   logic [3:0] gnt_dir;
   logic       any_elig;
   logic       run_tick;
   logic       grant;
   logic [3:0] grant_vec;

   // ------------------------------------------------------------------
   // Arbitration
   // ------------------------------------------------------------------
   assign elig_dir = swap_order(pend & ~occ);

   nexys_starship_rr_arb4 u_arb (
      .req (elig_dir),
      .ptr (rr_ptr),
      .gnt (gnt_dir),
      .any (any_elig)
   );

   // The tick that ends the grace period is already the first run tick,
   // so a request waiting through GRACE_TICKS ticks is granted on the next.
   assign run_tick = tick && game_active &&
                     ((state == S_RUN) || ((state == S_GRACE) && (grace_cnt == 8'd0)));

   assign grant = run_tick && (cooldown == 4'd0) &&
                  (popcount4(occ) < 3'(MAX_ACTIVE)) && any_elig;

   assign grant_vec = grant ? swap_order(gnt_dir) : 4'b0000;

   // ------------------------------------------------------------------
   // State machine
   // ------------------------------------------------------------------
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (!game_active) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE:  state_nxt = S_GRACE;
            S_GRACE: if (tick && (grace_cnt == 8'd0)) state_nxt = S_RUN;
            S_RUN:   state_nxt = S_RUN;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         grace_cnt <= '0;
      end else if (game_active) begin
         if (state == S_IDLE) begin
            grace_cnt <= 8'(GRACE_TICKS);
         end else if ((state == S_GRACE) && tick && (grace_cnt != 8'd0)) begin
            grace_cnt <= grace_cnt - 8'd1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Requests, occupancy, cooldown and grant bookkeeping
   // ------------------------------------------------------------------
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         pend     <= '0;
         occ      <= '0;
         spawn_q  <= '0;
         cooldown <= '0;
         rr_ptr   <= '0;
         total    <= '0;
      end else if (!game_active) begin
         // Abort: rr_ptr and total survive across games.
         pend     <= '0;
         occ      <= '0;
         spawn_q  <= '0;
         cooldown <= '0;
      end else begin
         spawn_q <= grant_vec;
         // The winner is always unoccupied, so a clear can never hit it.
         occ     <= (occ & ~slot_clear) | grant_vec;
         if (state != S_IDLE) begin
            pend <= (pend | (rand_req & ~occ)) & ~grant_vec;
         end
         if (grant) begin
            rr_ptr   <= onehot_idx(gnt_dir) + 2'd1;
            cooldown <= reload;
            if (total != 8'hFF) total <= total + 8'd1;
         end else if (tick && (cooldown != 4'd0)) begin
            cooldown <= cooldown - 4'd1;
         end
      end
   end

`ifdef NEXYS_STARSHIP_SPAWN_RAMP_EN
   logic [7:0] ramp_cnt;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         reload   <= 4'(COOLDOWN_TICKS);
         ramp_cnt <= '0;
      end else if (!game_active) begin
         reload   <= 4'(COOLDOWN_TICKS);
         ramp_cnt <= '0;
      end else if (grant) begin
         // The grant above loads the current reload; the shrink applies
         // from the following grant onward.
         if (ramp_cnt == 8'(RAMP_SPAWNS - 1)) begin
            ramp_cnt <= '0;
            if (reload > 4'(MIN_COOLDOWN)) reload <= reload - 4'd1;
         end else begin
            ramp_cnt <= ramp_cnt + 8'd1;
         end
      end
   end
`else
   assign reload = 4'(COOLDOWN_TICKS);
`endif

   // ------------------------------------------------------------------
   // Outputs: an abort hides the pulse and occupancy in the same cycle.
   // ------------------------------------------------------------------
   assign spawn        = spawn_q & {4{game_active}};
   assign occupied     = occ & {4{game_active}};
   assign active_count = popcount4(occupied);
   assign spawn_total  = total;

endmodule
`default_nettype wire

// File: tb/tb_nexys_starship_spawn_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nexys_starship_spawn_sched
//  Purpose  : Directed self-checking bench for nexys_starship_spawn_sched.
//             Instance a uses defaults (MAX 3, cooldown 4, grace 8);
//             instance b uses MAX 4, cooldown 0, grace 0.
//  Revision : 1.0  initial release
// ============================================================================
module tb_nexys_starship_spawn_sched;

   logic       Clk;
   logic       Reset;

   logic       a_tick, a_ga;
   logic [3:0] a_req, a_clr, a_spawn, a_occ;
   logic [2:0] a_cnt;
   logic [7:0] a_total;

   logic       b_tick, b_ga;
   logic [3:0] b_req, b_clr, b_spawn, b_occ;
   logic [2:0] b_cnt;
   logic [7:0] b_total;

   int n_checks;
   int n_pass;
   logic [3:0] seen;

   nexys_starship_spawn_sched u_dut_a (
      .Clk          (Clk),
      .Reset        (Reset),
      .tick         (a_tick),
      .game_active  (a_ga),
      .rand_req     (a_req),
      .slot_clear   (a_clr),
      .spawn        (a_spawn),
      .occupied     (a_occ),
      .active_count (a_cnt),
      .spawn_total  (a_total)
   );

   nexys_starship_spawn_sched #(
      .MAX_ACTIVE     (4),
      .COOLDOWN_TICKS (0),
      .GRACE_TICKS    (0)
   ) u_dut_b (
      .Clk          (Clk),
      .Reset        (Reset),
      .tick         (b_tick),
      .game_active  (b_ga),
      .rand_req     (b_req),
      .slot_clear   (b_clr),
      .spawn        (b_spawn),
      .occupied     (b_occ),
      .active_count (b_cnt),
      .spawn_total  (b_total)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge Clk);
      #1;
   endtask

   task automatic tick_a();
      a_tick = 1'b1;
      cyc();
      a_tick = 1'b0;
   endtask

   task automatic tick_b();
      b_tick = 1'b1;
      cyc();
      b_tick = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      Reset  = 1'b1;
      a_tick = 1'b0; a_ga = 1'b0; a_req = 4'b0; a_clr = 4'b0;
      b_tick = 1'b0; b_ga = 1'b0; b_req = 4'b0; b_clr = 4'b0;
      repeat (3) cyc();
      check("rst_spawn",  32'(a_spawn), 32'h0);
      check("rst_occ",    32'(a_occ),   32'h0);
      check("rst_cnt",    32'(a_cnt),   32'h0);
      check("rst_total",  32'(a_total), 32'h0);
      check("rst_b_total",32'(b_total), 32'h0);
      Reset = 1'b0;
      cyc();

      // ---------------- instance a: grace, cooldown, cap, abort ----------
      a_ga  = 1'b1;
      a_req = 4'b1000;
      cyc();
      cyc();
      seen = 4'b0;
      for (int t = 0; t < 8; t++) begin
         tick_a();
         seen = seen | a_spawn;
      end
      check("grace_no_spawn", 32'(seen), 32'h0);
      tick_a();
      check("grace_tick9_spawn", 32'(a_spawn), 32'h8);
      check("grace_occ",         32'(a_occ),   32'h8);
      check("grace_cnt",         32'(a_cnt),   32'h1);
      check("grace_total",       32'(a_total), 32'h1);
      cyc();
      check("pulse_one_cycle",   32'(a_spawn), 32'h0);

      a_req = 4'b1111;
      cyc();
      a_req = 4'b0000;
      seen = 4'b0;
      for (int t = 0; t < 4; t++) begin
         tick_a();
         seen = seen | a_spawn;
      end
      check("cooldown_block", 32'(seen), 32'h0);
      tick_a();
      check("cooldown_5th_btm", 32'(a_spawn), 32'h4);
      seen = 4'b0;
      for (int t = 0; t < 4; t++) begin
         tick_a();
         seen = seen | a_spawn;
      end
      tick_a();
      check("rr_left", 32'(a_spawn | seen), 32'h2);
      check("cap_occ", 32'(a_occ), 32'he);
      check("cap_cnt", 32'(a_cnt), 32'h3);
      seen = 4'b0;
      for (int t = 0; t < 5; t++) begin
         tick_a();
         seen = seen | a_spawn;
      end
      check("max_active_stall", 32'(seen),    32'h0);
      check("stall_total",      32'(a_total), 32'h3);

      a_clr = 4'b1000;
      cyc();
      a_clr = 4'b0000;
      check("clear_occ", 32'(a_occ), 32'h6);
      check("clear_cnt", 32'(a_cnt), 32'h2);
      tick_a();
      check("after_clear_right", 32'(a_spawn), 32'h1);
      check("total_4",           32'(a_total), 32'h4);
      a_ga = 1'b0;
      #1;
      check("abort_spawn_gated", 32'(a_spawn), 32'h0);
      cyc();
      check("abort_occ",   32'(a_occ),   32'h0);
      check("abort_cnt",   32'(a_cnt),   32'h0);
      check("abort_total", 32'(a_total), 32'h4);

      // ---------------- instance b: order, clear+grant, saturation -------
      b_ga = 1'b1;
      cyc();
      b_req = 4'b1110;
      cyc();
      b_req = 4'b0000;
      tick_b();
      check("b_rr_top",  32'(b_spawn), 32'h8);
      tick_b();
      check("b_rr_btm",  32'(b_spawn), 32'h4);
      tick_b();
      check("b_rr_left", 32'(b_spawn), 32'h2);
      check("b_occ3",    32'(b_occ),   32'he);
      check("b_cnt3",    32'(b_cnt),   32'h3);

      b_req = 4'b0001;
      cyc();
      b_req  = 4'b0000;
      b_clr  = 4'b0100;
      b_tick = 1'b1;
      cyc();
      b_clr  = 4'b0000;
      b_tick = 1'b0;
      check("b_clr_grant_spawn", 32'(b_spawn), 32'h1);
      check("b_clr_grant_occ",   32'(b_occ),   32'hb);
      check("b_clr_grant_cnt",   32'(b_cnt),   32'h3);
      check("b_total4",          32'(b_total), 32'h4);
      tick_b();
      check("b_no_eligible", 32'(b_spawn), 32'h0);

      for (int i = 0; i < 256; i++) begin
         b_clr = 4'b1000;
         cyc();
         b_clr = 4'b0000;
         b_req = 4'b1000;
         cyc();
         b_req = 4'b0000;
         tick_b();
      end
      check("b_total_sat", 32'(b_total), 32'hff);
      check("b_last_spawn", 32'(b_spawn), 32'h8);
      Reset = 1'b1;
      #1;
      check("async_reset_spawn", 32'(b_spawn), 32'h0);
      check("async_reset_total", 32'(b_total), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
